// File: rtl/terrain_crater_ctrl.sv
// Terrain crater carver: clears a disc of terrain bits one column at a time by
// read-modify-write of the column-organised terrain SRAM, reading only during display blanking.
module terrain_crater_ctrl #(
    parameter int NCOLS  = 640,
    parameter int FLOOR  = 479,
    parameter int RMAX_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              vid_blank,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [RMAX_W-1:0] req_r,
    input  logic [9:0]        disp_addr,
    output logic [9:0]        read_addr,
    output logic [9:0]        write_addr,
    output logic              we,
    output logic [511:0]      terrain_in,
    input  logic [511:0]      terrain_out,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, SETUP, CALC, RD, WAIT, WR, NEXT, DONE} state_t;

    localparam logic signed [11:0] LAST_COL = 12'(NCOLS - 1);

    state_t              state, state_nx;
    logic [9:0]          cx, cy, col, x_hi;
    logic [RMAX_W-1:0]   r, dy;
    logic [2*RMAX_W-1:0] r2;
    logic [511:0]        buffer, mask;

    // Column span of the crater, clipped to the screen; widened so cx+r cannot overflow.
    logic signed [11:0] cx_s, r_s, x_lo_s, x_hi_s;
    logic [9:0]         x_lo, x_hi_clip;

    assign cx_s      = $signed({2'b00, cx});
    assign r_s       = $signed({{(12-RMAX_W){1'b0}}, r});
    assign x_lo_s    = cx_s - r_s;
    assign x_hi_s    = cx_s + r_s;
    assign x_lo      = (x_lo_s < 0) ? 10'd0 : x_lo_s[9:0];
    assign x_hi_clip = (x_hi_s > LAST_COL) ? LAST_COL[9:0] : x_hi_s[9:0];

    // Half-height search: dy shrinks from r until dx^2 + dy^2 fits inside r^2.
    logic [9:0]          dx;
    logic [19:0]         dx_sq;
    logic [2*RMAX_W-1:0] dy_sq;
    logic                too_far;

    assign dx      = (col >= cx) ? col - cx : cx - col;
    assign dx_sq   = {10'd0, dx} * {10'd0, dx};
    assign dy_sq   = {{RMAX_W{1'b0}}, dy} * {{RMAX_W{1'b0}}, dy};
    assign too_far = (21'(dx_sq) + 21'(dy_sq)) > 21'(r2);

    // Signed row bounds let the mask clip at row 0 and at FLOOR instead of wrapping.
    logic signed [11:0] row_lo, row_hi;

    assign row_lo = $signed({2'b00, cy}) - $signed({{(12-RMAX_W){1'b0}}, dy});
    assign row_hi = $signed({2'b00, cy}) + $signed({{(12-RMAX_W){1'b0}}, dy});

    always_comb begin
        for (int i = 0; i < 512; i++)
            mask[i] = (i >= int'(row_lo)) && (i <= int'(row_hi)) && (i <= FLOOR);
    end

    assign write_addr = col;
    assign terrain_in = buffer & ~mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: every output and the next state get a default first, so no latch is inferred.
        state_nx  = state;
        req_ready = 1'b0;
        we        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        read_addr = disp_addr;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = init_done;
                if (req_valid && init_done) state_nx = SETUP;
            end
            SETUP: state_nx = CALC;
            CALC:  if (!too_far || dy == '0) state_nx = RD;
            RD: begin
                if (vid_blank) begin
                    read_addr = col;
                    state_nx  = WAIT;
                end
            end
            WAIT: state_nx = WR;
            WR: begin
                we       = 1'b1;
                state_nx = NEXT;
            end
            NEXT: state_nx = (col >= x_hi) ? DONE : CALC;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx     <= '0;
            cy     <= '0;
            r      <= '0;
            r2     <= '0;
            col    <= '0;
            x_hi   <= '0;
            dy     <= '0;
            // NOTE: the column buffer is a plain register, not a RAM, so it takes the reset too.
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && init_done) begin
                        cx <= req_x;
                        cy <= req_y;
                        r  <= req_r;
                    end
                end
                SETUP: begin
                    r2   <= {{RMAX_W{1'b0}}, r} * {{RMAX_W{1'b0}}, r};
                    col  <= x_lo;
                    x_hi <= x_hi_clip;
                    dy   <= r;
                end
                CALC: if (too_far && dy != '0) dy <= dy - RMAX_W'(1);
                WAIT: buffer <= terrain_out;
                NEXT: begin
                    if (col < x_hi) begin
                        col <= col + 10'd1;
                        dy  <= r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_terrain_crater_ctrl.sv
// Scoreboard bench for terrain_crater_ctrl: a disc model predicts every column write,
// a monitor checks each write/done as the DUT presents it, and an SRAM model holds the terrain.
module tb_terrain_crater_ctrl;
    localparam int NCOLS  = 640;
    localparam int FLOOR  = 479;
    localparam int RMAX_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init_done = 1'b0;
    logic              vid_blank = 1'b1;
    logic              req_valid = 1'b0;
    logic [9:0]        req_x = '0;
    logic [9:0]        req_y = '0;
    logic [RMAX_W-1:0] req_r = '0;
    logic [9:0]        disp_addr = '0;
    logic              req_ready, we, busy, done;
    logic [9:0]        read_addr, write_addr;
    logic [511:0]      terrain_in;
    logic [511:0]      terrain_out = '0;

    terrain_crater_ctrl #(.NCOLS(NCOLS), .FLOOR(FLOOR), .RMAX_W(RMAX_W)) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .vid_blank(vid_blank),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_r(req_r), .disp_addr(disp_addr), .read_addr(read_addr),
        .write_addr(write_addr), .we(we), .terrain_in(terrain_in),
        .terrain_out(terrain_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Terrain SRAM: one-cycle read latency, write on we.
    logic [511:0] sram    [0:NCOLS-1];
    logic [511:0] ref_mem [0:NCOLS-1];
    logic [511:0] flat;

    always @(posedge clk) begin
        if (we) sram[write_addr] <= terrain_in;
        terrain_out <= sram[read_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int col;
        int lo;
        int hi;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int writes_seen = 0;
    int done_seen = 0;
    bit rand_blank = 1'b0;

    function automatic logic [511:0] clear_rows(input logic [511:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) d[i] = 1'b0;
        return d;
    endfunction

    // Disc model: each column in range gets the largest dy with dx^2 + dy^2 <= r^2.
    task automatic push_crater(input int x, input int y, input int r);
        int c_lo, c_hi;
        c_lo = (x - r < 0) ? 0 : x - r;
        c_hi = (x + r > NCOLS - 1) ? NCOLS - 1 : x + r;
        for (int c = c_lo; c <= c_hi; c++) begin
            int dx, dy;
            wr_exp_t e;
            dx = (c > x) ? c - x : x - c;
            dy = 0;
            while ((dy + 1) * (dy + 1) + dx * dx <= r * r) dy++;
            e.col = c;
            e.lo  = (y - dy < 0) ? 0 : y - dy;
            e.hi  = (y + dy > FLOOR) ? FLOOR : y + dy;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                check("write_expected", exp_q.size() != 0, 1);
                check("busy_during_we", busy, 1);
                if (exp_q.size() != 0) begin
                    wr_exp_t e;
                    logic [511:0] exp_data;
                    e = exp_q.pop_front();
                    exp_data = clear_rows(ref_mem[e.col], e.lo, e.hi);
                    check("write_addr", write_addr, e.col);
                    check("write_data", terrain_in, exp_data);
                    ref_mem[e.col] = exp_data;
                end
                writes_seen++;
            end
            if (done) begin
                check("done_after_last_write", exp_q.size(), 0);
                done_seen++;
            end
            if (!vid_blank) check("read_addr_tracks_disp", read_addr, disp_addr);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            disp_addr = 10'($urandom_range(0, NCOLS - 1));
            if (rand_blank) vid_blank = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input int x, input int y, input int r);
        int n;
        @(posedge clk);
        #1;
        req_x = 10'(x);
        req_y = 10'(y);
        req_r = RMAX_W'(r);
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready || n >= 2000) break;
            n++;
        end
        check("accept", req_ready, 1);
        if (req_ready) push_crater(x, y, r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_within_budget", done_seen != start, 1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (writes_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("writes_within_budget", writes_seen >= target, 1);
    endtask

    initial begin
        int base, mism;
        flat = '0;
        for (int i = 310; i < 512; i++) flat[i] = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            sram[c]    = (c == NCOLS - 1) ? '1 : flat;
            ref_mem[c] = sram[c];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", we, 0);
        check("rst_read_addr", read_addr, disp_addr);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // init_done low blocks acceptance; the accepted crater then completes without it
        req_x = 10'd50; req_y = 10'd400; req_r = RMAX_W'(2); req_valid = 1'b1;
        base = writes_seen;
        repeat (10) begin
            @(negedge clk);
            check("no_ready_without_init", req_ready, 0);
            check("idle_without_init", busy, 0);
        end
        check("no_writes_without_init", writes_seen - base, 0);
        @(posedge clk);
        #1;
        init_done = 1'b1;
        @(negedge clk);
        check("ready_after_init", req_ready, 1);
        if (req_ready) push_crater(50, 400, 2);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        init_done = 1'b0;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        wait_done(5000);
        init_done = 1'b1;

        // Flat terrain crater
        base = writes_seen;
        issue(100, 310, 3);
        wait_done(5000);
        check("c100_writes", writes_seen - base, 7);
        check("c100_rows", sram[100][316:305], 12'b111000000000);
        check("c97_rows", sram[97][312:308], 5'b11000);
        check("c96_untouched", sram[96], flat);
        check("c104_untouched", sram[104], flat);

        // Left-edge clip and floor clip
        base = writes_seen;
        issue(2, 470, 10);
        wait_done(5000);
        check("edge_writes", writes_seen - base, 13);
        check("c2_cleared", sram[2][479:460], 20'd0);
        check("c2_above_floor", sram[2][511:480], 32'hffffffff);
        check("c2_row459", sram[2][459], 1);
        check("c13_untouched", sram[13], flat);

        // Display owns the SRAM for 50 cycles
        vid_blank = 1'b0;
        issue(400, 350, 4);
        base = writes_seen;
        repeat (50) @(posedge clk);
        #1;
        check("stall_no_write", writes_seen - base, 0);
        check("stall_busy", busy, 1);
        vid_blank = 1'b1;
        wait_done(5000);
        check("stall_writes", writes_seen - base, 9);

        // r=0 at the last column; a request during busy is dropped
        base = writes_seen;
        issue(639, 0, 0);
        req_x = 10'd10; req_y = 10'd400; req_r = RMAX_W'(5); req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("ready_low_while_busy", req_ready, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done(5000);
        repeat (5) @(posedge clk);
        #1;
        check("r0_single_write", writes_seen - base, 1);
        check("r0_idle", busy, 0);
        check("c639_bits", sram[639][1:0], 2'b10);

        // Reset after the third write of an r=5 crater
        base = writes_seen;
        issue(300, 330, 5);
        wait_writes(base + 3, 5000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_read_addr", read_addr, disp_addr);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_writes", writes_seen - base, 3);
        check("c295_bit", sram[295][330], 0);
        check("c298_untouched", sram[298], flat);

        // Randomised craters with random blanking
        rand_blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            issue($urandom_range(0, NCOLS - 1), $urandom_range(0, 559), $urandom_range(0, 20));
            wait_done(30000);
        end
        issue(320, 500, 63);
        wait_done(30000);
        issue(5, 600, 10);
        wait_done(30000);
        rand_blank = 1'b0;
        vid_blank = 1'b1;
        repeat (5) @(posedge clk);

        mism = 0;
        for (int c = 0; c < NCOLS; c++)
            if (sram[c] !== ref_mem[c]) mism++;
        check("final_terrain_mismatch_cols", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
